i2c_seq_config: RTL and testbench
=================================

Name: i2c_seq_config

Overview:
- Parametrised I2C register-sequence configurator for CMOS sensor bring-up and runtime tuning.
- Walks an externally supplied register table (index out, entry in) and issues one write per entry to the existing I2C byte controller through its GO/END/ACK handshake.
- Adds NACK retry with a bounded count, an error report, a full-table restart, and a single-entry live update (e.g. exposure) without re-running the whole table.
- Sits between the host-side control logic and the I2C controller; runs entirely on the system clock and generates the controller clock enable.

Parameters:
- CLK_DIV, 1250: system clocks per oI2C_CLK_EN pulse (50 MHz / 40 kHz tick = 20 kHz SCLK).
- LUT_SIZE, 25: number of table entries, indices 0..LUT_SIZE-1.
- IDX_W, 6: width of index buses; must satisfy 2^IDX_W >= LUT_SIZE.
- SLAVE_ADDR, 8'hBA: 8-bit write address placed in oI2C_DATA[MSB byte].
- ADDR_W, 8: sensor register address width.
- REG_W, 16: sensor register data width.
- MAX_RETRY, 3: extra attempts after a NACK before the entry is declared failed.
- PWRUP_WAIT, 50000: iCLK cycles to wait after reset before the first write.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous active-high reset.
- oLUT_INDEX  out  IDX_W  table index currently requested.
- iLUT_DATA  in  ADDR_W+REG_W  {reg_addr, reg_data} for oLUT_INDEX, combinational from the table.
- oI2C_CLK_EN  out  1  one-cycle tick every CLK_DIV cycles; controller clock enable.
- oI2C_DATA  out  8+ADDR_W+REG_W  {SLAVE_ADDR, iLUT_DATA} latched at issue.
- oI2C_GO  out  1  transfer request.
- iI2C_END  in  1  controller transfer complete (iCLK domain).
- iI2C_ACK  in  1  1 = NACK seen in the completed transfer.
- iRESTART  in  1  pulse: rewrite the whole table.
- iUPD_REQ  in  1  pulse: rewrite one entry.
- iUPD_INDEX  in  IDX_W  entry to rewrite; sampled with iUPD_REQ.
- oBUSY  out  1  a transfer or sequence is in progress.
- oDONE  out  1  one-cycle pulse when a full sequence or an update completes.
- oERR  out  1  sticky: some entry exhausted its retries.
- oERR_INDEX  out  IDX_W  first failing index since the last restart.

Behaviour:
- Reset values: all outputs 0; state PWRUP; divider 0; retry count 0; pending flags cleared.
- Divider: counts 0..CLK_DIV-1 and pulses oI2C_CLK_EN at CLK_DIV-1. It free-runs and is cleared only by reset.

States:
- PWRUP: count PWRUP_WAIT cycles, then go to LOAD with index 0 and oBUSY=1.
- LOAD: oI2C_DATA <= {SLAVE_ADDR, iLUT_DATA}; oI2C_GO <= 1; go to XFER.
- XFER: hold GO until iI2C_END=1. In that cycle GO <= 0, sample iI2C_ACK, go to GAP.
- GAP: wait until iI2C_END=0, then evaluate:
  - ACK ok: retry count <= 0; advance.
  - NACK with retry < MAX_RETRY: retry+1, go to LOAD at the same index.
  - NACK with retries exhausted: oERR <= 1; latch oERR_INDEX if oERR was 0; retry count <= 0; advance.
- Advance, sequence mode: if index == LUT_SIZE-1, go to IDLE with oDONE pulse; else index+1, go to LOAD.
- Advance, update mode: go to IDLE with oDONE pulse.
- IDLE: oBUSY=0.
  - Pending restart has priority: index 0, clear oERR/oERR_INDEX, go to LOAD in sequence mode.
  - Otherwise a pending update: index <= stored index, go to LOAD in update mode.

Requests:
- iRESTART and iUPD_REQ are captured in any state into one-deep pending flags, and are acted on only at IDLE or at a transfer boundary (GAP exit).
- A restart pending at GAP exit aborts the current sequence (no oDONE) and restarts at index 0.
- A later iUPD_REQ overwrites an earlier pending index (last wins).
- Restart and update on the same cycle: both flags set; the restart is served first and the update after it.
- An iUPD_INDEX >= LUT_SIZE is ignored.

Other rules:
- GO never rises while iI2C_END=1.
- oLUT_INDEX always equals the index being loaded or in flight.
- Reset mid-transfer: everything is cleared immediately and GO drops asynchronously; the sequence restarts from PWRUP.

Test Plan:
- Reset, PWRUP_WAIT=10, LUT_SIZE=4, model always ACKs -> 4 transfers with oI2C_DATA = {8'hBA, entries 0..3} in order; one oDONE pulse; oBUSY falls in the same cycle; oERR=0.
- Model NACKs index 2 twice, then ACKs (MAX_RETRY=3) -> index 2 issued 3 times; oERR=0; sequence completes with oDONE.
- Model NACKs index 1 always -> index 1 issued 4 times; oERR=1, oERR_INDEX=1; indices 2,3 still written; oDONE asserted.
- Idle, iUPD_REQ with index 2 (table entry {8'h09, 16'h04A0}) -> exactly one transfer with oI2C_DATA=32'hBA0904A0, then oDONE; then iUPD_INDEX=7 with LUT_SIZE=4 -> no transfer.
- iRESTART during index 2 -> index 2 completes, next issue is index 0, no oDONE for the aborted run, oERR cleared; iUPD_REQ(1) and iRESTART on the same cycle -> full table written, then index 1 written, two oDONE pulses.
- Assert iRST while GO=1 -> GO=0 and all outputs 0 immediately; after release, PWRUP_WAIT elapses before index 0 is reissued; oI2C_CLK_EN period measured at CLK_DIV.

Source files
------------

// File: rtl/i2c_seq_config.sv
// i2c_seq_config
// Walks an external register table and writes each entry to a sensor over an
// existing I2C byte controller (GO/END/ACK handshake). Each NACK gets a bounded
// number of retries, and a failure is reported as a sticky error together with
// the first failing index. The host can ask for a full-table restart or for a
// single-entry live update. The block also generates the controller's clock
// enable from the system clock.

module i2c_seq_config #(
    parameter int          CLK_DIV    = 1250,
    parameter int          LUT_SIZE   = 25,
    parameter int          IDX_W      = 6,
    parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
    parameter int          ADDR_W     = 8,
    parameter int          REG_W      = 16,
    parameter int          MAX_RETRY  = 3,
    parameter int          PWRUP_WAIT = 50000
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    output logic [IDX_W-1:0]             oLUT_INDEX,
    input  logic [ADDR_W+REG_W-1:0]      iLUT_DATA,
    output logic                         oI2C_CLK_EN,
    output logic [8+ADDR_W+REG_W-1:0]    oI2C_DATA,
    output logic                         oI2C_GO,
    input  logic                         iI2C_END,
    input  logic                         iI2C_ACK,
    input  logic                         iRESTART,
    input  logic                         iUPD_REQ,
    input  logic [IDX_W-1:0]             iUPD_INDEX,
    output logic                         oBUSY,
    output logic                         oDONE,
    output logic                         oERR,
    output logic [IDX_W-1:0]             oERR_INDEX
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW_W  = (PWRUP_WAIT > 1) ? $clog2(PWRUP_WAIT) : 1;
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [PW_W-1:0]  PW_LAST      = PW_W'((PWRUP_WAIT > 0) ? PWRUP_WAIT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(LUT_SIZE - 1);
    localparam logic [RT_W-1:0]  RETRY_LIMIT  = RT_W'(MAX_RETRY);
    // One extra bit so that LUT_SIZE == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0]   LUT_SIZE_EXT = (IDX_W + 1)'(LUT_SIZE);

    typedef enum logic [2:0] {
        PWRUP,
        LOAD,
        XFER,
        GAP,
        IDLE
    } state_t;

    // Clock-enable divider.
    logic [DIV_W-1:0] divCnt_q;
    logic [DIV_W-1:0] divCnt_d;
    logic             clkEn_q;

    // Sequencer state.
    state_t                      state_q;
    logic [PW_W-1:0]             waitCnt_q;
    logic [IDX_W-1:0]            idx_q;
    logic [RT_W-1:0]             retry_q;
    logic                        nack_q;
    logic                        updMode_q;

    // Registered outputs.
    logic                        go_q;
    logic [8+ADDR_W+REG_W-1:0]   data_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;
    logic [IDX_W-1:0]            errIdx_q;

    // One-deep host request flags.
    logic                        rstPend_q;
    logic                        updPend_q;
    logic [IDX_W-1:0]            updIdx_q;

    // Decode helpers for the transfer-boundary decision.
    logic lastEntry;
    logic retryAvail;
    logic updIdxValid;

    assign lastEntry   = (idx_q == IDX_LAST);
    assign retryAvail  = (retry_q < RETRY_LIMIT);
    assign updIdxValid = ({1'b0, iUPD_INDEX} < LUT_SIZE_EXT);

    // Next divider count: wraps after CLK_DIV-1 so the tick period is CLK_DIV.
    always_comb begin
        divCnt_d = divCnt_q + 1'b1;
        if (divCnt_q == DIV_LAST) begin
            divCnt_d = '0;
        end
    end

    // Free-running divider; the tick is registered so that it lines up with the terminal count.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            divCnt_q <= '0;
            clkEn_q  <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            clkEn_q  <= (divCnt_d == DIV_LAST);
        end
    end

    // Sequencer FSM: power-up wait, issue/handshake/retry per entry, and host request capture.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= PWRUP;
            waitCnt_q <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            nack_q    <= 1'b0;
            updMode_q <= 1'b0;
            go_q      <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            errIdx_q  <= '0;
            rstPend_q <= 1'b0;
            updPend_q <= 1'b0;
            updIdx_q  <= '0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                PWRUP: begin
                    // Sensor needs settling time after power-up before the first write.
                    if (waitCnt_q == PW_LAST) begin
                        waitCnt_q <= '0;
                        idx_q     <= '0;
                        updMode_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end

                LOAD: begin
                    // Never raise GO while the controller still shows END from a previous transfer.
                    if (!iI2C_END) begin
                        data_q  <= {SLAVE_ADDR, iLUT_DATA};
                        go_q    <= 1'b1;
                        state_q <= XFER;
                    end
                end

                XFER: begin
                    if (iI2C_END) begin
                        go_q    <= 1'b0;
                        nack_q  <= iI2C_ACK;
                        state_q <= GAP;
                    end
                end

                GAP: begin
                    // Decide only once END has dropped, so that the next GO starts a fresh handshake.
                    if (!iI2C_END) begin
                        if (rstPend_q) begin
                            // A restart aborts whatever was running; no completion pulse.
                            rstPend_q <= 1'b0;
                            idx_q     <= '0;
                            updMode_q <= 1'b0;
                            retry_q   <= '0;
                            err_q     <= 1'b0;
                            errIdx_q  <= '0;
                            state_q   <= LOAD;
                        end else if (nack_q && retryAvail) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= LOAD;
                        end else begin
                            if (nack_q) begin
                                err_q <= 1'b1;
                                if (!err_q) begin
                                    errIdx_q <= idx_q;
                                end
                            end
                            retry_q <= '0;
                            if (updMode_q || lastEntry) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= LOAD;
                            end
                        end
                    end
                end

                IDLE: begin
                    // Restart outranks update; a simultaneous update stays pending and runs afterwards.
                    if (rstPend_q) begin
                        rstPend_q <= 1'b0;
                        idx_q     <= '0;
                        updMode_q <= 1'b0;
                        err_q     <= 1'b0;
                        errIdx_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end else if (updPend_q) begin
                        updPend_q <= 1'b0;
                        idx_q     <= updIdx_q;
                        updMode_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end

                default: begin
                    state_q <= PWRUP;
                end
            endcase

            // Capture comes last so that a request arriving in the same cycle its flag is consumed still sticks.
            if (iRESTART) begin
                rstPend_q <= 1'b1;
            end
            if (iUPD_REQ && updIdxValid) begin
                updPend_q <= 1'b1;
                updIdx_q  <= iUPD_INDEX;
            end
        end
    end

    assign oLUT_INDEX  = idx_q;
    assign oI2C_CLK_EN = clkEn_q;
    assign oI2C_DATA   = data_q;
    assign oI2C_GO     = go_q;
    assign oBUSY       = busy_q;
    assign oDONE       = done_q;
    assign oERR        = err_q;
    assign oERR_INDEX  = errIdx_q;

endmodule

// File: tb/tb_i2c_seq_config.sv
// tb_i2c_seq_config
// Drives i2c_seq_config with a small 4-entry register table and a behavioural
// I2C controller. The controller answers each GO with a one-cycle END and can
// NACK selected indices. It logs every completed transfer for comparison
// against hand-derived index orders.

module tb_i2c_seq_config;

    localparam int CLK_DIV    = 5;
    localparam int LUT_SIZE   = 4;
    localparam int IDX_W      = 3;
    localparam int MAX_RETRY  = 3;
    localparam int PWRUP_WAIT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  lutIdx;
    logic [23:0] lutData;
    logic        clkEn;
    logic [31:0] dataO;
    logic        goO;
    logic        endI = 1'b0;
    logic        ackI = 1'b0;
    logic        restart = 1'b0;
    logic        updReq = 1'b0;
    logic [2:0]  updIdx = 3'd0;
    logic        busyO;
    logic        doneO;
    logic        errO;
    logic [2:0]  errIdxO;

    int checks = 0;
    int errors = 0;

    i2c_seq_config #(
        .CLK_DIV    (CLK_DIV),
        .LUT_SIZE   (LUT_SIZE),
        .IDX_W      (IDX_W),
        .SLAVE_ADDR (8'hBA),
        .ADDR_W     (8),
        .REG_W      (16),
        .MAX_RETRY  (MAX_RETRY),
        .PWRUP_WAIT (PWRUP_WAIT)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .oLUT_INDEX  (lutIdx),
        .iLUT_DATA   (lutData),
        .oI2C_CLK_EN (clkEn),
        .oI2C_DATA   (dataO),
        .oI2C_GO     (goO),
        .iI2C_END    (endI),
        .iI2C_ACK    (ackI),
        .iRESTART    (restart),
        .iUPD_REQ    (updReq),
        .iUPD_INDEX  (updIdx),
        .oBUSY       (busyO),
        .oDONE       (doneO),
        .oERR        (errO),
        .oERR_INDEX  (errIdxO)
    );

    always #5 clk = ~clk;

    // Register table contents: {reg_addr, reg_data}.
    function automatic logic [23:0] lutEntry(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'h01_1111;
            3'd1:    return 24'h05_2222;
            3'd2:    return 24'h09_04A0;
            3'd3:    return 24'h20_3333;
            default: return 24'h00_0000;
        endcase
    endfunction

    assign lutData = lutEntry(lutIdx);

    // Controller model knobs: 0 = always ACK, 1 = NACK index 2 twice, 2 = NACK index 1 always.
    int nackMode  = 0;
    int modeEpoch = 0;

    int   lat       = 0;
    int   seenEpoch = 0;
    int   nackGiven = 0;
    logic nk;
    logic [2:0]  logIdx[$];
    logic [31:0] logData[$];

    // Behavioural I2C controller: END for one cycle four cycles after GO, with ACK chosen by nackMode.
    always @(negedge clk) begin
        if (rst) begin
            endI = 1'b0;
            ackI = 1'b0;
            lat  = 0;
        end else if (endI) begin
            endI = 1'b0;
            ackI = 1'b0;
        end else if (goO) begin
            if (lat == 3) begin
                if (seenEpoch != modeEpoch) begin
                    seenEpoch = modeEpoch;
                    nackGiven = 0;
                end
                nk = 1'b0;
                if (nackMode == 1 && lutIdx == 3'd2 && nackGiven < 2) begin
                    nk = 1'b1;
                    nackGiven++;
                end else if (nackMode == 2 && lutIdx == 3'd1) begin
                    nk = 1'b1;
                end
                endI = 1'b1;
                ackI = nk;
                logIdx.push_back(lutIdx);
                logData.push_back(dataO);
                lat = 0;
            end else begin
                lat++;
            end
        end else begin
            lat = 0;
        end
    end

    int   doneCnt     = 0;
    int   doneBusyBad = 0;
    logic prevBusy    = 1'b0;

    // Done monitor: count pulses and flag any pulse where BUSY did not fall in that same cycle.
    always @(negedge clk) begin
        if (doneO) begin
            doneCnt++;
            if (busyO || !prevBusy) begin
                doneBusyBad++;
            end
        end
        prevBusy = busyO;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    // Pulse restart and/or an update request for one cycle, starting at the current negedge.
    task automatic applyStimulus(input logic doRestart, input logic doUpd, input logic [2:0] idx);
        restart = doRestart;
        updReq  = doUpd;
        updIdx  = idx;
        @(negedge clk);
        restart = 1'b0;
        updReq  = 1'b0;
    endtask

    task automatic waitDones(input string name, input int target, input int maxCycles);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            if (doneCnt >= target) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) reportTimeout(name);
    endtask

    task automatic waitGo(input string name, input logic [2:0] idx, input int maxCycles);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            if (goO && lutIdx == idx) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) reportTimeout(name);
    endtask

    // Compare the transfers logged since 'base' with an index list packed one nibble per entry, entry 0 in the low nibble.
    task automatic checkSeq(input string name, input int base, input int n, input logic [63:0] seq);
        int         got;
        logic [2:0] ei;
        got = logIdx.size() - base;
        checkOutput({name, "_count"}, 64'(got), 64'(n));
        for (int i = 0; i < n; i++) begin
            ei = seq[4*i +: 3];
            if (base + i < logIdx.size()) begin
                checkOutput($sformatf("%s_idx%0d", name, i), 64'(logIdx[base + i]), 64'(ei));
                checkOutput($sformatf("%s_data%0d", name, i), 64'(logData[base + i]), 64'({8'hBA, lutEntry(ei)}));
            end
        end
    endtask

    typedef struct {
        logic        isUpd;
        logic [2:0]  updIdx;
        int          mode;
        int          nXfer;
        logic [63:0] seq;
        int          nDone;
        logic        expErr;
        logic [2:0]  expErrIdx;
    } seqVec_t;

    seqVec_t vecs[5];

    initial begin
        int base;
        int doneBase;
        int n;

        vecs[0] = '{1'b0, 3'd0, 0, 4, 64'h3210,    1, 1'b0, 3'd0};
        vecs[1] = '{1'b0, 3'd0, 1, 6, 64'h322210,  1, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 3'd0, 2, 7, 64'h3211110, 1, 1'b1, 3'd1};
        vecs[3] = '{1'b1, 3'd2, 0, 1, 64'h2,       1, 1'b1, 3'd1};
        vecs[4] = '{1'b1, 3'd7, 0, 0, 64'h0,       0, 1'b1, 3'd1};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_go",     64'(goO),     64'd0);
        checkOutput("rst_busy",   64'(busyO),   64'd0);
        checkOutput("rst_done",   64'(doneO),   64'd0);
        checkOutput("rst_err",    64'(errO),    64'd0);
        checkOutput("rst_erridx", 64'(errIdxO), 64'd0);
        checkOutput("rst_idx",    64'(lutIdx),  64'd0);
        checkOutput("rst_data",   64'(dataO),   64'd0);
        checkOutput("rst_clken",  64'(clkEn),   64'd0);

        // Power-up run of the whole table with all ACKs.
        base     = logIdx.size();
        doneBase = doneCnt;
        rst = 1'b0;
        waitDones("pwr_done_wait", doneBase + 1, 600);
        repeat (5) @(negedge clk);
        checkSeq("pwr", base, 4, 64'h3210);
        checkOutput("pwr_done",     64'(doneCnt - doneBase), 64'd1);
        checkOutput("pwr_err",      64'(errO),  64'd0);
        checkOutput("pwr_busy",     64'(busyO), 64'd0);
        checkOutput("pwr_busydone", 64'(doneBusyBad), 64'd0);

        // Table-driven restart and update scenarios.
        for (int v = 0; v < 5; v++) begin
            base      = logIdx.size();
            doneBase  = doneCnt;
            nackMode  = vecs[v].mode;
            modeEpoch = modeEpoch + 1;
            if (vecs[v].isUpd) applyStimulus(1'b0, 1'b1, vecs[v].updIdx);
            else               applyStimulus(1'b1, 1'b0, 3'd0);
            if (vecs[v].nDone > 0) waitDones($sformatf("v%0d_done_wait", v), doneBase + 1, 800);
            else                   repeat (300) @(negedge clk);
            repeat (5) @(negedge clk);
            checkSeq($sformatf("v%0d", v), base, vecs[v].nXfer, vecs[v].seq);
            checkOutput($sformatf("v%0d_done", v),   64'(doneCnt - doneBase), 64'(vecs[v].nDone));
            checkOutput($sformatf("v%0d_err", v),    64'(errO),    64'(vecs[v].expErr));
            checkOutput($sformatf("v%0d_erridx", v), 64'(errIdxO), 64'(vecs[v].expErrIdx));
            checkOutput($sformatf("v%0d_busy", v),   64'(busyO),   64'd0);
        end
        checkOutput("upd2_const", 64'(logData[logData.size() - 1]), 64'h00000000BA0904A0);

        // Restart arriving while index 2 is in flight after index 1 has failed.
        base      = logIdx.size();
        doneBase  = doneCnt;
        nackMode  = 2;
        modeEpoch = modeEpoch + 1;
        applyStimulus(1'b1, 1'b0, 3'd0);
        waitGo("abort_go2_wait", 3'd2, 800);
        checkOutput("abort_err_before",    64'(errO),    64'd1);
        checkOutput("abort_erridx_before", 64'(errIdxO), 64'd1);
        nackMode  = 0;
        modeEpoch = modeEpoch + 1;
        applyStimulus(1'b1, 1'b0, 3'd0);
        waitDones("abort_done_wait", doneBase + 1, 1000);
        repeat (5) @(negedge clk);
        checkSeq("abort", base, 10, 64'h3210211110);
        checkOutput("abort_done",   64'(doneCnt - doneBase), 64'd1);
        checkOutput("abort_err",    64'(errO),    64'd0);
        checkOutput("abort_erridx", 64'(errIdxO), 64'd0);

        // Restart and update on the same cycle: full table first, then the single entry.
        base     = logIdx.size();
        doneBase = doneCnt;
        applyStimulus(1'b1, 1'b1, 3'd1);
        waitDones("both_done_wait", doneBase + 2, 1000);
        repeat (5) @(negedge clk);
        checkSeq("both", base, 5, 64'h13210);
        checkOutput("both_done",     64'(doneCnt - doneBase), 64'd2);
        checkOutput("both_busydone", 64'(doneBusyBad), 64'd0);

        // Clock-enable period.
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (clkEn) break;
            @(negedge clk);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (clkEn) break;
        end
        checkOutput("clken_period", 64'(n), 64'(CLK_DIV));

        // Reset in the middle of a transfer, then power-up delay before index 0 is reissued.
        applyStimulus(1'b1, 1'b0, 3'd0);
        waitGo("rstmid_go_wait", 3'd0, 200);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_go",   64'(goO),    64'd0);
        checkOutput("rstmid_busy", 64'(busyO),  64'd0);
        checkOutput("rstmid_data", 64'(dataO),  64'd0);
        checkOutput("rstmid_idx",  64'(lutIdx), 64'd0);
        checkOutput("rstmid_err",  64'(errO),   64'd0);
        checkOutput("rstmid_clk",  64'(clkEn),  64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n++;
            if (goO) break;
        end
        checkOutput("rstmid_pwrup_delay", 64'(n), 64'(PWRUP_WAIT + 1));
        checkOutput("rstmid_reissue_idx", 64'(lutIdx), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
